window_addr_gen: RTL

- Parametrised successor to the WOS filter's address sequencer.
- Walks an H x W image stored row-major in memory and, for each output pixel in raster order, issues the full N x N neighbourhood as a stream of read addresses. It then issues one write address for the filtered result.
- Adds selectable border handling, independent source and destination base addresses, and valid/ready backpressure on both ports.
- Sits between the config registers and the memory arbiter; read beats feed the weighted-order-statistics kernel.

---
 rtl/wos_pkg.sv | 21 ++
 rtl/coord_to_addr.sv | 48 ++++
 rtl/window_addr_gen.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/wos_pkg.sv
// wos_pkg: shared types and constants for the WOS window address generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wos_pkg;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Border handling selector, matches cfg_mode encoding.
    localparam logic MODE_ZERO = 1'b0;
    localparam logic MODE_REPL = 1'b1;

    // Default largest legal kernel size (odd).
    localparam int KMAX_DEF = 7;

endpackage

// File: rtl/coord_to_addr.sv
// coord_to_addr: maps a signed (x,y) sample coordinate to a linear row-major address, with clamp or pad at the border.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: i_base base address; i_x/i_y signed coordinate; i_w/i_h image size;
//        i_clamp 1 = replicate border, 0 = pad; o_addr address; o_pad sample is outside the image.
module coord_to_addr #(
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 8
) (
    input  logic [ADDR_W-1:0]       i_base,
    input  logic signed [DIM_W+1:0] i_x,
    input  logic signed [DIM_W+1:0] i_y,
    input  logic [DIM_W-1:0]        i_w,
    input  logic [DIM_W-1:0]        i_h,
    input  logic                    i_clamp,
    output logic [ADDR_W-1:0]       o_addr,
    output logic                    o_pad
);
    localparam int CW = DIM_W + 2;

    logic signed [CW-1:0] w_wm1;
    logic signed [CW-1:0] w_hm1;
    logic signed [CW-1:0] w_xc;
    logic signed [CW-1:0] w_yc;
    logic                 w_out;

    always_comb begin
        // W and H are at least 1 once the run is accepted, so the limits are >= 0.
        w_wm1 = signed'({2'b00, i_w}) - CW'(1);
        w_hm1 = signed'({2'b00, i_h}) - CW'(1);

        w_out = (i_x < 0) || (i_x > w_wm1) || (i_y < 0) || (i_y > w_hm1);

        w_xc = (i_x < 0) ? '0 : ((i_x > w_wm1) ? w_wm1 : i_x);
        w_yc = (i_y < 0) ? '0 : ((i_y > w_hm1) ? w_hm1 : i_y);

        o_pad = !i_clamp && w_out;

        // Padded beats carry the base address; the kernel never reads memory for them.
        if (o_pad) begin
            o_addr = i_base;
        end else begin
            o_addr = i_base + ADDR_W'($unsigned(w_yc)) * ADDR_W'(i_w)
                            + ADDR_W'($unsigned(w_xc));
        end
    end

endmodule

// File: rtl/window_addr_gen.sv
// window_addr_gen: raster-walks an HxW image, issuing N*N neighbourhood reads then one write address per pixel.
// Latency: first read 1 cycle after start; next request 1 cycle after each handshake; done 1 cycle after the last write.
// Backpressure: rd/wr payload held stable while valid&!ready; valid only drops on a handshake; rd and wr never both valid.
// Ports: clk/rst; start + cfg_* (latched on start in IDLE); rd_* read stream with pad/first/last flags;
//        wr_* write stream; busy (not IDLE), done (1-cycle pulse), err (sticky bad config).
module window_addr_gen
    import wos_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 8,
    parameter int KMAX   = KMAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_h,
    input  logic [DIM_W-1:0]  cfg_w,
    input  logic [3:0]        cfg_n,
    input  logic              cfg_mode,
    input  logic [ADDR_W-1:0] cfg_src,
    input  logic [ADDR_W-1:0] cfg_dst,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_pad,
    output logic              win_first,
    output logic              win_last,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int CW = DIM_W + 2;
    typedef logic signed [CW-1:0] coord_t;

    // Architectural state
    state_t            r_state;
    logic [DIM_W-1:0]  r_x, r_y, r_w, r_h;
    coord_t            r_dx, r_dy, r_k;
    logic              r_mode;
    logic [ADDR_W-1:0] r_src, r_dst;
    logic              r_err;

    // Registered outputs
    logic              r_rd_valid, r_rd_pad, r_win_first, r_win_last;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_wr_valid;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_busy, r_done;

    // Next-state values
    state_t            w_nxt_state;
    logic [DIM_W-1:0]  w_nxt_x, w_nxt_y, w_nxt_w, w_nxt_h;
    coord_t            w_nxt_dx, w_nxt_dy, w_nxt_k;
    logic              w_nxt_mode, w_nxt_err;
    logic [ADDR_W-1:0] w_nxt_src, w_nxt_dst;

    logic              w_cfg_bad;
    coord_t            w_cfg_k;
    coord_t            w_rd_xx, w_rd_yy, w_wr_xx, w_wr_yy;
    logic [ADDR_W-1:0] w_rd_addr, w_wr_addr;
    logic              w_rd_pad, w_wr_pad_unused;

    assign w_cfg_bad = !cfg_n[0] || (int'(cfg_n) > KMAX) || (cfg_h == '0) || (cfg_w == '0);
    assign w_cfg_k   = coord_t'(cfg_n >> 1);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_x     = r_x;
        w_nxt_y     = r_y;
        w_nxt_dx    = r_dx;
        w_nxt_dy    = r_dy;
        w_nxt_k     = r_k;
        w_nxt_w     = r_w;
        w_nxt_h     = r_h;
        w_nxt_mode  = r_mode;
        w_nxt_src   = r_src;
        w_nxt_dst   = r_dst;
        w_nxt_err   = r_err;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nxt_w    = cfg_w;
                    w_nxt_h    = cfg_h;
                    w_nxt_k    = w_cfg_k;
                    w_nxt_mode = cfg_mode;
                    w_nxt_src  = cfg_src;
                    w_nxt_dst  = cfg_dst;
                    w_nxt_x    = '0;
                    w_nxt_y    = '0;
                    w_nxt_dx   = -w_cfg_k;
                    w_nxt_dy   = -w_cfg_k;
                    if (w_cfg_bad) begin
                        w_nxt_state = DONE;
                        w_nxt_err   = 1'b1;
                    end else begin
                        w_nxt_state = READ;
                        w_nxt_err   = 1'b0;
                    end
                end
            end
            READ: begin
                // Column-major walk: dy is the inner loop, dx the outer.
                if (rd_ready) begin
                    if (r_dy == r_k) begin
                        if (r_dx == r_k) begin
                            w_nxt_state = WRITE;
                        end else begin
                            w_nxt_dx = r_dx + CW'(1);
                            w_nxt_dy = -r_k;
                        end
                    end else begin
                        w_nxt_dy = r_dy + CW'(1);
                    end
                end
            end
            WRITE: begin
                if (wr_ready) begin
                    if ((r_x == r_w - DIM_W'(1)) && (r_y == r_h - DIM_W'(1))) begin
                        w_nxt_state = DONE;
                    end else begin
                        if (r_x == r_w - DIM_W'(1)) begin
                            w_nxt_x = '0;
                            w_nxt_y = r_y + DIM_W'(1);
                        end else begin
                            w_nxt_x = r_x + DIM_W'(1);
                        end
                        w_nxt_dx    = -r_k;
                        w_nxt_dy    = -r_k;
                        w_nxt_state = READ;
                    end
                end
            end
            DONE: begin
                w_nxt_state = IDLE;
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    // Addresses are computed from the next-state counters so the request
    // registers hold exactly the beat that is presented next cycle.
    assign w_rd_xx = coord_t'({2'b00, w_nxt_x}) + w_nxt_dx;
    assign w_rd_yy = coord_t'({2'b00, w_nxt_y}) + w_nxt_dy;
    assign w_wr_xx = coord_t'({2'b00, w_nxt_x});
    assign w_wr_yy = coord_t'({2'b00, w_nxt_y});

    coord_to_addr #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_rd_addr (
        .i_base  (w_nxt_src),
        .i_x     (w_rd_xx),
        .i_y     (w_rd_yy),
        .i_w     (w_nxt_w),
        .i_h     (w_nxt_h),
        .i_clamp (w_nxt_mode == MODE_REPL),
        .o_addr  (w_rd_addr),
        .o_pad   (w_rd_pad)
    );

    // Output pixel is always inside the image, so the clamp is never exercised.
    coord_to_addr #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_wr_addr (
        .i_base  (w_nxt_dst),
        .i_x     (w_wr_xx),
        .i_y     (w_wr_yy),
        .i_w     (w_nxt_w),
        .i_h     (w_nxt_h),
        .i_clamp (1'b0),
        .o_addr  (w_wr_addr),
        .o_pad   (w_wr_pad_unused)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_w         <= '0;
            r_h         <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_k         <= '0;
            r_mode      <= 1'b0;
            r_src       <= '0;
            r_dst       <= '0;
            r_err       <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_pad    <= 1'b0;
            r_win_first <= 1'b0;
            r_win_last  <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_x         <= w_nxt_x;
            r_y         <= w_nxt_y;
            r_w         <= w_nxt_w;
            r_h         <= w_nxt_h;
            r_dx        <= w_nxt_dx;
            r_dy        <= w_nxt_dy;
            r_k         <= w_nxt_k;
            r_mode      <= w_nxt_mode;
            r_src       <= w_nxt_src;
            r_dst       <= w_nxt_dst;
            r_err       <= w_nxt_err;
            r_rd_valid  <= (w_nxt_state == READ);
            r_rd_addr   <= (w_nxt_state == READ) ? w_rd_addr : '0;
            r_rd_pad    <= (w_nxt_state == READ) && w_rd_pad;
            r_win_first <= (w_nxt_state == READ) && (w_nxt_dx == -w_nxt_k) && (w_nxt_dy == -w_nxt_k);
            r_win_last  <= (w_nxt_state == READ) && (w_nxt_dx == w_nxt_k) && (w_nxt_dy == w_nxt_k);
            r_wr_valid  <= (w_nxt_state == WRITE);
            r_wr_addr   <= (w_nxt_state == WRITE) ? w_wr_addr : '0;
            r_busy      <= (w_nxt_state != IDLE);
            r_done      <= (w_nxt_state == DONE);
        end
    end

    assign rd_valid  = r_rd_valid;
    assign rd_addr   = r_rd_addr;
    assign rd_pad    = r_rd_pad;
    assign win_first = r_win_first;
    assign win_last  = r_win_last;
    assign wr_valid  = r_wr_valid;
    assign wr_addr   = r_wr_addr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
